// File: rtl/sys_issue_ctrl.sv
// Issue-side sequencer for the system functional unit: waits for the pipeline to drain,
// fires the unit once, captures its result and hands it to writeback.
// Optional drain watchdog: define SYS_ISSUE_CTRL_DRAIN_TIMEOUT_EN.
module sys_issue_ctrl #(
    parameter int  DATA_W           = 64,
    parameter int  TAG_W            = 6,
    parameter int  DRAIN_TIMEOUT    = 1024,
    parameter type decoded_alu_op_t = logic [5:0]
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  decoded_alu_op_t i_req_op,
    input  logic [DATA_W-1:0] i_req_src1,
    input  logic [DATA_W-1:0] i_req_src2,
    input  logic [TAG_W-1:0]  i_req_tag,
    input  logic            i_req_serialize,
    input  logic            i_pipe_idle,
    input  logic            i_kill,
    output logic            o_fu_enabled,
    output decoded_alu_op_t o_fu_op,
    output logic [DATA_W-1:0] o_fu_src1,
    output logic [DATA_W-1:0] o_fu_src2,
    input  logic [DATA_W-1:0] i_fu_dest,
    output logic            o_wb_valid,
    input  logic            i_wb_ready,
    output logic [DATA_W-1:0] o_wb_dest,
    output logic [TAG_W-1:0]  o_wb_tag,
    output logic            o_flush_req,
    output logic            o_busy,
    output logic            o_timeout
);

    // state | meaning
    // IDLE  | no op held; accepting from issue
    // DRAIN | op latched; waiting for older work to retire
    // EXEC  | sys_unit enabled for this single cycle
    // CAPT  | sys_unit result registered; latch it
    // WB    | result offered to writeback
    // FLUSH | serializing op done; one-cycle flush request
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_EXEC,
        S_CAPT,
        S_WB,
        S_FLUSH
    } state_t;

    if (DRAIN_TIMEOUT < 1) begin : g_bad_timeout
        $error("DRAIN_TIMEOUT must be at least 1");
    end

    state_t            state_q, state_d;
    decoded_alu_op_t   op_q;
    logic [DATA_W-1:0] src1_q, src2_q, dest_q;
    logic [TAG_W-1:0]  tag_q;
    logic              serialize_q;

    logic accept;
    logic timeout_hit;
    logic fu_en_d, wb_valid_d, flush_d, timeout_d;

    assign o_req_ready = (state_q == S_IDLE) & ~i_kill & i_rst_n;
    assign accept      = i_req_valid & o_req_ready;

`ifdef SYS_ISSUE_CTRL_DRAIN_TIMEOUT_EN
    localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_TIMEOUT);

    // Down-counter loaded on DRAIN entry; terminal count means DRAIN_TIMEOUT stalled cycles.
    logic [CNT_W-1:0] drain_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            drain_cnt_q <= CNT_LOAD;
        end else if (accept) begin
            drain_cnt_q <= CNT_LOAD;
        end else if (state_q == S_DRAIN && !i_pipe_idle && drain_cnt_q != '0) begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
        end
    end

    assign timeout_hit = (drain_cnt_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fu_en_d    = 1'b0;
        wb_valid_d = 1'b0;
        flush_d    = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_kill) begin
                    state_d = S_IDLE;
                end else if (i_pipe_idle) begin
                    state_d = S_EXEC;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_EXEC: begin
                fu_en_d = 1'b1;
                state_d = S_CAPT;
            end
            S_CAPT: begin
                state_d = S_WB;
            end
            S_WB: begin
                wb_valid_d = 1'b1;
                if (i_wb_ready) state_d = serialize_q ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            tag_q       <= '0;
            serialize_q <= 1'b0;
            dest_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q        <= i_req_op;
                src1_q      <= i_req_src1;
                src2_q      <= i_req_src2;
                tag_q       <= i_req_tag;
                serialize_q <= i_req_serialize;
            end
            if (state_q == S_CAPT) dest_q <= i_fu_dest;
        end
    end

    // Control outputs are forced low while reset is held, even before the reset edge.
    assign o_fu_enabled = fu_en_d & i_rst_n;
    assign o_wb_valid   = wb_valid_d & i_rst_n;
    assign o_flush_req  = flush_d & i_rst_n;
    assign o_timeout    = timeout_d & i_rst_n;
    assign o_busy       = (state_q != S_IDLE) & i_rst_n;

    assign o_fu_op   = op_q;
    assign o_fu_src1 = src1_q;
    assign o_fu_src2 = src2_q;
    assign o_wb_dest = dest_q;
    assign o_wb_tag  = tag_q;

endmodule

// File: tb/tb_sys_issue_ctrl.sv
// Directed bench for sys_issue_ctrl: cycle vector table plus hand sequences for
// drain wait, kill handling, mid-op reset and (when enabled) the drain timeout.
module tb_sys_issue_ctrl;

    localparam int DW = 64;
    localparam int TW = 6;
`ifdef SYS_ISSUE_CTRL_DRAIN_TIMEOUT_EN
    localparam int DRAIN_WAIT = 7;
`else
    localparam int DRAIN_WAIT = 10;
`endif

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [5:0]    req_op;
    logic [DW-1:0] req_src1, req_src2;
    logic [TW-1:0] req_tag;
    logic          req_ser;
    logic          pipe_idle;
    logic          kill;
    logic          fu_en;
    logic [5:0]    fu_op;
    logic [DW-1:0] fu_src1, fu_src2, fu_dest;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_dest;
    logic [TW-1:0] wb_tag;
    logic          flush_req;
    logic          busy;
    logic          timeout;

    int n_checks = 0;
    int n_fail   = 0;

    sys_issue_ctrl #(
        .DATA_W(DW),
        .TAG_W(TW),
        .DRAIN_TIMEOUT(8),
        .decoded_alu_op_t(logic [5:0])
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_op(req_op),
        .i_req_src1(req_src1),
        .i_req_src2(req_src2),
        .i_req_tag(req_tag),
        .i_req_serialize(req_ser),
        .i_pipe_idle(pipe_idle),
        .i_kill(kill),
        .o_fu_enabled(fu_en),
        .o_fu_op(fu_op),
        .o_fu_src1(fu_src1),
        .o_fu_src2(fu_src2),
        .i_fu_dest(fu_dest),
        .o_wb_valid(wb_valid),
        .i_wb_ready(wb_ready),
        .o_wb_dest(wb_dest),
        .o_wb_tag(wb_tag),
        .o_flush_req(flush_req),
        .o_busy(busy),
        .o_timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          rst_n, valid;
        logic [5:0]    op;
        logic [DW-1:0] s1, s2;
        logic [TW-1:0] tag;
        logic          ser, pidle, kill;
        logic [DW-1:0] fdest;
        logic          wbr;
        logic          e_rdy, e_fen, e_wbv, e_flush, e_busy;
        logic [DW-1:0] e_dest;
        logic [TW-1:0] e_tag;
        logic [5:0]    e_op;
        logic [DW-1:0] e_s1;
    } vec_t;

    function automatic vec_t mk(
        input int rst, input int vld, input int op, input logic [DW-1:0] s1,
        input logic [DW-1:0] s2, input int tag, input int ser, input int pidle,
        input int kl, input logic [DW-1:0] fdest, input int wbr,
        input int rdy, input int fen, input int wbv, input int fl, input int bsy,
        input logic [DW-1:0] edest, input int etag, input int eop, input logic [DW-1:0] es1);
        vec_t v;
        v.rst_n = rst[0];  v.valid = vld[0];  v.op = op[5:0];
        v.s1 = s1;         v.s2 = s2;         v.tag = tag[TW-1:0];
        v.ser = ser[0];    v.pidle = pidle[0]; v.kill = kl[0];
        v.fdest = fdest;   v.wbr = wbr[0];
        v.e_rdy = rdy[0];  v.e_fen = fen[0];  v.e_wbv = wbv[0];
        v.e_flush = fl[0]; v.e_busy = bsy[0]; v.e_dest = edest;
        v.e_tag = etag[TW-1:0]; v.e_op = eop[5:0]; v.e_s1 = es1;
        return v;
    endfunction

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        req_valid = 1'b0; req_op = '0; req_src1 = '0; req_src2 = '0; req_tag = '0;
        req_ser = 1'b0; kill = 1'b0;
    endtask

    localparam logic [DW-1:0] A = 64'hA5A5_0000_1111_2222;
    localparam logic [DW-1:0] B = 64'h0000_0000_0000_0F0F;
    localparam logic [DW-1:0] D = 64'hDEAD_BEEF_0123_4567;
    localparam logic [DW-1:0] G = 64'h0000_0000_0000_FFFF;

    vec_t vecs[17];

    initial begin
        //            rst vld op s1      s2      tag   ser pid kil fdest  wbr  rdy fen wbv fl bsy edest  etag  eop es1
        vecs[0]  = mk(0, 0, 0, 64'h0,  64'h0,  0,    0, 0, 0, 64'h0, 0,   0, 0, 0, 0, 0, 64'h0, 0,    0, 64'h0);
        vecs[1]  = mk(0, 1, 0, 64'h0,  64'h0,  0,    0, 1, 0, 64'h0, 0,   0, 0, 0, 0, 0, 64'h0, 0,    0, 64'h0);
        vecs[2]  = mk(1, 1, 3, 64'h11, 64'h22, 5,    0, 1, 0, 64'h0, 1,   1, 0, 0, 0, 0, 64'h0, 0,    0, 64'h0);
        vecs[3]  = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, 64'h0, 1,   0, 0, 0, 0, 1, 64'h0, 5,    3, 64'h11);
        vecs[4]  = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, 64'h0, 1,   0, 1, 0, 0, 1, 64'h0, 5,    3, 64'h11);
        vecs[5]  = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, 64'h0, 1,   0, 0, 0, 0, 1, 64'h0, 5,    3, 64'h11);
        vecs[6]  = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, G,     1,   0, 0, 1, 0, 1, 64'h0, 5,    3, 64'h11);
        vecs[7]  = mk(1, 1, 7, A,      B,      'h2a, 1, 1, 0, G,     0,   1, 0, 0, 0, 0, 64'h0, 5,    3, 64'h11);
        vecs[8]  = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, G,     0,   0, 0, 0, 0, 1, 64'h0, 'h2a, 7, A);
        vecs[9]  = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, G,     0,   0, 1, 0, 0, 1, 64'h0, 'h2a, 7, A);
        vecs[10] = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, D,     0,   0, 0, 0, 0, 1, 64'h0, 'h2a, 7, A);
        vecs[11] = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, G,     0,   0, 0, 1, 0, 1, D,     'h2a, 7, A);
        vecs[12] = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, G,     0,   0, 0, 1, 0, 1, D,     'h2a, 7, A);
        vecs[13] = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, G,     0,   0, 0, 1, 0, 1, D,     'h2a, 7, A);
        vecs[14] = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, G,     1,   0, 0, 1, 0, 1, D,     'h2a, 7, A);
        vecs[15] = mk(1, 1, 1, 64'h5,  64'h5,  1,    0, 1, 0, G,     1,   0, 0, 0, 1, 1, D,     'h2a, 7, A);
        vecs[16] = mk(1, 0, 0, 64'h0,  64'h0,  0,    0, 1, 0, G,     1,   1, 0, 0, 0, 0, D,     'h2a, 7, A);

        rst_n = 1'b0; drive_idle(); pipe_idle = 1'b0; fu_dest = '0; wb_ready = 1'b0;

        // Basic op, then a serializing op with writeback backpressure
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;  req_valid = vecs[i].valid; req_op = vecs[i].op;
            req_src1 = vecs[i].s1;  req_src2 = vecs[i].s2;     req_tag = vecs[i].tag;
            req_ser = vecs[i].ser;  pipe_idle = vecs[i].pidle; kill = vecs[i].kill;
            fu_dest = vecs[i].fdest; wb_ready = vecs[i].wbr;
            #1;
            chk_b($sformatf("v%0d req_ready", i), req_ready, vecs[i].e_rdy);
            chk_b($sformatf("v%0d fu_enabled", i), fu_en, vecs[i].e_fen);
            chk_b($sformatf("v%0d wb_valid", i), wb_valid, vecs[i].e_wbv);
            chk_b($sformatf("v%0d flush_req", i), flush_req, vecs[i].e_flush);
            chk_b($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
            chk_b($sformatf("v%0d timeout", i), timeout, 1'b0);
            chk_w($sformatf("v%0d wb_dest", i), wb_dest, vecs[i].e_dest);
            chk_w($sformatf("v%0d wb_tag", i), 64'(wb_tag), 64'(vecs[i].e_tag));
            chk_w($sformatf("v%0d fu_op", i), 64'(fu_op), 64'(vecs[i].e_op));
            chk_w($sformatf("v%0d fu_src1", i), fu_src1, vecs[i].e_s1);
        end

        // Drain wait with pipe busy, then kill asserted in WB is ignored
        @(negedge clk);
        drive_idle(); req_valid = 1'b1; req_op = 6'd2; req_src1 = 64'd5; req_src2 = 64'd6;
        req_tag = 6'd9; pipe_idle = 1'b0; wb_ready = 1'b1; fu_dest = '0;
        #1 chk_b("dw accept ready", req_ready, 1'b1);
        for (int i = 0; i < DRAIN_WAIT; i++) begin
            @(negedge clk); req_valid = 1'b0;
            #1;
            chk_b($sformatf("dw%0d fu_enabled", i), fu_en, 1'b0);
            chk_b($sformatf("dw%0d busy", i), busy, 1'b1);
            chk_b($sformatf("dw%0d timeout", i), timeout, 1'b0);
        end
        @(negedge clk); pipe_idle = 1'b1;
        #1 chk_b("dw rise fu_enabled", fu_en, 1'b0);
        @(negedge clk);
        #1 chk_b("dw exec fu_enabled", fu_en, 1'b1);
        chk_w("dw exec src2", fu_src2, 64'd6);
        @(negedge clk); fu_dest = 64'h1234;
        #1 chk_b("dw capt fu_enabled", fu_en, 1'b0);
        @(negedge clk); kill = 1'b1; fu_dest = G;
        #1;
        chk_b("wbkill wb_valid", wb_valid, 1'b1);
        chk_w("wbkill wb_dest", wb_dest, 64'h1234);
        chk_w("wbkill wb_tag", 64'(wb_tag), 64'd9);
        @(negedge clk); kill = 1'b0;
        #1;
        chk_b("wbkill done busy", busy, 1'b0);
        chk_b("wbkill done wb_valid", wb_valid, 1'b0);
        chk_b("wbkill done flush", flush_req, 1'b0);

        // Kill in the second DRAIN cycle drops the op
        @(negedge clk); req_valid = 1'b1; req_tag = 6'd3; pipe_idle = 1'b0;
        #1 chk_b("kd accept ready", req_ready, 1'b1);
        @(negedge clk); req_valid = 1'b0;
        #1 chk_b("kd drain1 busy", busy, 1'b1);
        @(negedge clk); kill = 1'b1;
        #1 chk_b("kd drain2 ready", req_ready, 1'b0);
        @(negedge clk); kill = 1'b0; pipe_idle = 1'b1;
        #1;
        chk_b("kd idle busy", busy, 1'b0);
        chk_b("kd idle ready", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk_b($sformatf("kd after%0d fu_enabled", i), fu_en, 1'b0);
            chk_b($sformatf("kd after%0d wb_valid", i), wb_valid, 1'b0);
        end

        // Reset while in WB of a serializing op
        @(negedge clk); req_valid = 1'b1; req_op = 6'd5; req_src1 = 64'd77; req_tag = 6'h3c;
        req_ser = 1'b1; wb_ready = 1'b0;
        #1 chk_b("rst accept ready", req_ready, 1'b1);
        @(negedge clk); drive_idle();
        @(negedge clk);
        @(negedge clk); fu_dest = 64'd99;
        @(negedge clk);
        #1;
        chk_b("rst wb_valid before", wb_valid, 1'b1);
        chk_w("rst wb_dest before", wb_dest, 64'd99);
        @(negedge clk); rst_n = 1'b0; wb_ready = 1'b1;
        #1;
        chk_b("rst held ready", req_ready, 1'b0);
        chk_b("rst held wb_valid", wb_valid, 1'b0);
        @(negedge clk);
        #1;
        chk_b("rst ready", req_ready, 1'b0);
        chk_b("rst fu_enabled", fu_en, 1'b0);
        chk_b("rst wb_valid", wb_valid, 1'b0);
        chk_b("rst flush", flush_req, 1'b0);
        chk_b("rst busy", busy, 1'b0);
        chk_b("rst timeout", timeout, 1'b0);
        chk_w("rst wb_dest", wb_dest, 64'h0);
        chk_w("rst wb_tag", 64'(wb_tag), 64'h0);
        chk_w("rst fu_op", 64'(fu_op), 64'h0);
        chk_w("rst fu_src1", fu_src1, 64'h0);
        chk_w("rst fu_src2", fu_src2, 64'h0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk_b("post rst ready", req_ready, 1'b1);
        chk_b("post rst flush", flush_req, 1'b0);
        @(negedge clk);
        #1;
        chk_b("post rst flush2", flush_req, 1'b0);
        chk_b("post rst wb_valid", wb_valid, 1'b0);

`ifdef SYS_ISSUE_CTRL_DRAIN_TIMEOUT_EN
        // Drain timeout with DRAIN_TIMEOUT=8
        @(negedge clk); req_valid = 1'b1; req_tag = 6'd4; pipe_idle = 1'b0;
        #1 chk_b("to accept ready", req_ready, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); req_valid = 1'b0;
            #1;
            chk_b($sformatf("to drain%0d timeout", i), timeout, 1'b0);
            chk_b($sformatf("to drain%0d busy", i), busy, 1'b1);
        end
        @(negedge clk);
        #1;
        chk_b("to pulse", timeout, 1'b1);
        chk_b("to pulse fu_enabled", fu_en, 1'b0);
        @(negedge clk);
        #1;
        chk_b("to after timeout", timeout, 1'b0);
        chk_b("to after busy", busy, 1'b0);
        chk_b("to after fu_enabled", fu_en, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
